// File: rtl/mem_stage_pkg.sv
// Shared encodings and constants for the memory stage of the 5-stage pipeline.
package mem_stage_pkg;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    localparam logic [1:0] LB_WORD     = 2'd0;
    localparam logic [1:0] LB_SIGNED   = 2'd1;
    localparam logic [1:0] LB_UNSIGNED = 2'd2;

    localparam logic [31:0] PIPE_RESET_PC = 32'h0000_3000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: store byte enables/replicated data and load byte
// extraction with sign or zero extension (little-endian).
module mem_byte_lane
    import mem_stage_pkg::*;
(
    input  logic [1:0]  byte_sel,
    input  logic        store_byte,
    input  logic [31:0] store_data,
    input  logic [1:0]  lbyte,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] lane_s;

    // Store lanes: a byte store replicates the byte so any lane can take it
    always_comb begin
        if (store_byte) begin
            be    = 4'b0001 << byte_sel;
            wdata = {4{store_data[7:0]}};
        end else begin
            be    = 4'b1111;
            wdata = store_data;
        end
    end

    // Pick the addressed byte out of the returned word
    always_comb begin
        case (byte_sel)
            2'd0:    lane_s = rdata[7:0];
            2'd1:    lane_s = rdata[15:8];
            2'd2:    lane_s = rdata[23:16];
            default: lane_s = rdata[31:24];
        endcase
    end

    // Extend the selected byte, or pass the whole word through
    always_comb begin
        case (lbyte)
            LB_SIGNED:   load_data = {{24{lane_s[7]}}, lane_s};
            LB_UNSIGNED: load_data = {24'h00_0000, lane_s};
            LB_WORD:     load_data = rdata;
            default:     load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory req/ack sequencing with timeout, pipeline stall,
// and the folded-in Mem/Wb pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = PIPE_RESET_PC,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Mem_busB,
    input  logic [31:0] Mem_ALUres,
    input  logic [31:0] Mem_instr,
    input  logic [31:0] Mem_pcadd4,
    input  logic [4:0]  Mem_Rw,
    input  logic        Mem_Overflow,
    input  logic        Mem_MemWr,
    input  logic [1:0]  Mem_MemtoReg,
    input  logic        Mem_RegWr,
    input  logic [1:0]  Mem_lbyte,
    input  logic        Mem_sbyte,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        Mem_stall,
    output logic        bus_err,
    output logic        Wb_RegWr,
    output logic [4:0]  Wb_Rw,
    output logic [31:0] Wb_busW,
    output logic [31:0] Wb_instr,
    output logic [31:0] Wb_pcadd4
);

    localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT_CYC);

    mem_state_e  state_r;
    logic [9:0]  wcnt_r;
    logic        memop_s;
    logic        timeout_s;
    logic        abort_s;
    logic        stall_s;
    logic [3:0]  lane_be_s;
    logic [31:0] lane_wdata_s;
    logic [31:0] load_data_s;
    logic [31:0] wb_data_s;

    mem_byte_lane u_byte_lane (
        .byte_sel   (Mem_ALUres[1:0]),
        .store_byte (Mem_sbyte),
        .store_data (Mem_busB),
        .lbyte      (Mem_lbyte),
        .rdata      (dm_rdata),
        .be         (lane_be_s),
        .wdata      (lane_wdata_s),
        .load_data  (load_data_s)
    );

    // Access qualification; an ack arriving with the timeout still completes
    always_comb begin
        memop_s   = (Mem_MemWr | (Mem_MemtoReg == MTR_MEM)) & ~Mem_Overflow;
        timeout_s = (state_r == ST_BUSY) && (wcnt_r == TIMEOUT_W);
        abort_s   = memop_s & timeout_s & ~dm_ack;
        stall_s   = memop_s & ~(dm_ack | abort_s);
    end

    assign Mem_stall = stall_s;
    assign bus_err   = abort_s;

    // Data-memory bus: loads always fetch the full word
    always_comb begin
        dm_req  = memop_s;
        dm_addr = {Mem_ALUres[31:2], 2'b00};
        if (memop_s) begin
            dm_we = Mem_MemWr;
            if (Mem_MemWr) begin
                dm_be    = lane_be_s;
                dm_wdata = lane_wdata_s;
            end else begin
                dm_be    = 4'b1111;
                dm_wdata = Mem_busB;
            end
        end else begin
            dm_we    = 1'b0;
            dm_be    = 4'b0000;
            dm_wdata = Mem_busB;
        end
    end

    // Writeback source select
    always_comb begin
        case (Mem_MemtoReg)
            MTR_ALU: wb_data_s = Mem_ALUres;
            MTR_MEM: wb_data_s = load_data_s;
            MTR_PC4: wb_data_s = Mem_pcadd4;
            default: wb_data_s = Mem_ALUres;
        endcase
    end

    // Access FSM; leaving BUSY when the memop vanishes keeps a stray state from lingering
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            wcnt_r  <= 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (memop_s && !dm_ack) begin
                        state_r <= ST_BUSY;
                        wcnt_r  <= 10'd1;
                    end else begin
                        state_r <= ST_IDLE;
                        wcnt_r  <= 10'd0;
                    end
                end
                ST_BUSY: begin
                    if (!memop_s || dm_ack || timeout_s) begin
                        state_r <= ST_IDLE;
                        wcnt_r  <= 10'd0;
                    end else begin
                        state_r <= ST_BUSY;
                        wcnt_r  <= wcnt_r + 10'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wcnt_r  <= 10'd0;
                end
            endcase
        end
    end

    // Mem/Wb register: bubble while stalled, zeroed data on an aborted access
    always_ff @(posedge clk) begin
        if (rst) begin
            Wb_RegWr  <= 1'b0;
            Wb_Rw     <= 5'd0;
            Wb_busW   <= 32'd0;
            Wb_instr  <= 32'd0;
            Wb_pcadd4 <= RESET_PC;
        end else if (stall_s) begin
            Wb_RegWr  <= 1'b0;
        end else if (abort_s) begin
            Wb_RegWr  <= 1'b0;
            Wb_Rw     <= Mem_Rw;
            Wb_busW   <= 32'd0;
            Wb_instr  <= Mem_instr;
            Wb_pcadd4 <= Mem_pcadd4;
        end else begin
            Wb_RegWr  <= Mem_RegWr & ~Mem_Overflow;
            Wb_Rw     <= Mem_Rw;
            Wb_busW   <= wb_data_s;
            Wb_instr  <= Mem_instr;
            Wb_pcadd4 <= Mem_pcadd4;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus wait-state,
// timeout and reset-during-access sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] Mem_busB;
    logic [31:0] Mem_ALUres;
    logic [31:0] Mem_instr;
    logic [31:0] Mem_pcadd4;
    logic [4:0]  Mem_Rw;
    logic        Mem_Overflow;
    logic        Mem_MemWr;
    logic [1:0]  Mem_MemtoReg;
    logic        Mem_RegWr;
    logic [1:0]  Mem_lbyte;
    logic        Mem_sbyte;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        Mem_stall;
    logic        bus_err;
    logic        Wb_RegWr;
    logic [4:0]  Wb_Rw;
    logic [31:0] Wb_busW;
    logic [31:0] Wb_instr;
    logic [31:0] Wb_pcadd4;

    int tests = 0;
    int fails = 0;

    mem_stage #(.RESET_PC(32'h0000_3000), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .Mem_busB(Mem_busB), .Mem_ALUres(Mem_ALUres), .Mem_instr(Mem_instr),
        .Mem_pcadd4(Mem_pcadd4), .Mem_Rw(Mem_Rw), .Mem_Overflow(Mem_Overflow),
        .Mem_MemWr(Mem_MemWr), .Mem_MemtoReg(Mem_MemtoReg), .Mem_RegWr(Mem_RegWr),
        .Mem_lbyte(Mem_lbyte), .Mem_sbyte(Mem_sbyte),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .Mem_stall(Mem_stall), .bus_err(bus_err),
        .Wb_RegWr(Wb_RegWr), .Wb_Rw(Wb_Rw), .Wb_busW(Wb_busW),
        .Wb_instr(Wb_instr), .Wb_pcadd4(Wb_pcadd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] busb;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        ovf;
        logic        memwr;
        logic [1:0]  mtr;
        logic        regwr;
        logic [1:0]  lbyte;
        logic        sbyte;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_regwr;
        logic [31:0] e_busw;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Mem_busB = 32'd0; Mem_ALUres = 32'd0; Mem_instr = 32'd0; Mem_pcadd4 = 32'd0;
        Mem_Rw = 5'd0; Mem_Overflow = 1'b0; Mem_MemWr = 1'b0; Mem_MemtoReg = 2'd0;
        Mem_RegWr = 1'b0; Mem_lbyte = 2'd0; Mem_sbyte = 1'b0;
        dm_ack = 1'b0; dm_rdata = 32'd0;
    endtask

    task automatic set_load(input logic [31:0] alu, input logic [1:0] lb,
                            input logic [4:0] rw, input logic [31:0] rdata);
        set_idle();
        Mem_ALUres = alu; Mem_MemtoReg = 2'd1; Mem_lbyte = lb; Mem_RegWr = 1'b1;
        Mem_Rw = rw; Mem_instr = 32'h8C00_0000 | {27'd0, rw}; Mem_pcadd4 = 32'h0000_0200;
        dm_rdata = rdata;
    endtask

    // Load acked after three wait cycles: three stalls with bubbles, then the result
    task automatic slow_load(input logic [1:0] lb, input logic [31:0] hold_busw,
                             input logic [31:0] exp_busw);
        set_load(32'h0000_1002, lb, 5'd9, 32'h0080_0000);
        for (int k = 0; k < 3; k++) begin
            #4;
            chk($sformatf("slow stall c%0d", k), {31'd0, Mem_stall}, 32'd1);
            chk($sformatf("slow bus_err c%0d", k), {31'd0, bus_err}, 32'd0);
            step();
            chk($sformatf("slow bubble c%0d", k), {31'd0, Wb_RegWr}, 32'd0);
            chk($sformatf("slow busW hold c%0d", k), Wb_busW, hold_busw);
        end
        dm_ack = 1'b1;
        #4;
        chk("slow stall at ack", {31'd0, Mem_stall}, 32'd0);
        step();
        chk("slow Wb_RegWr", {31'd0, Wb_RegWr}, 32'd1);
        chk("slow Wb_busW", Wb_busW, exp_busw);
        chk("slow Wb_Rw", {27'd0, Wb_Rw}, 32'd9);
    endtask

    // Unacked load with TIMEOUT_CYC=4: IDLE + BUSY wcnt 1..3 stall, abort at wcnt 4
    task automatic run_timeout(input logic [4:0] rw, input logic ack_last,
                               input logic [31:0] rdata, input logic exp_regwr,
                               input logic [31:0] exp_busw);
        set_load(32'h0000_1008, 2'd0, rw, rdata);
        for (int k = 0; k < 4; k++) begin
            #4;
            chk($sformatf("to stall c%0d", k), {31'd0, Mem_stall}, 32'd1);
            chk($sformatf("to bus_err c%0d", k), {31'd0, bus_err}, 32'd0);
            step();
            chk($sformatf("to bubble c%0d", k), {31'd0, Wb_RegWr}, 32'd0);
        end
        dm_ack = ack_last;
        #4;
        chk("to final stall", {31'd0, Mem_stall}, 32'd0);
        chk("to final bus_err", {31'd0, bus_err}, {31'd0, ~ack_last});
        chk("to final dm_req", {31'd0, dm_req}, 32'd1);
        step();
        chk("to Wb_RegWr", {31'd0, Wb_RegWr}, {31'd0, exp_regwr});
        chk("to Wb_busW", Wb_busW, exp_busw);
        chk("to Wb_Rw", {27'd0, Wb_Rw}, {27'd0, rw});
        chk("to bus_err after", {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        //            busb          alu           pc4           ovf   memwr mtr   regwr lbyte sbyte rdata         req   we    be       wdata         regwr busw
        vecs[0]  = '{32'h0,        32'h0000_1004, 32'h0000_0108, 1'b0, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{32'h0,        32'h0000_1002, 32'h0000_010C, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 32'h0080_0000, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{32'h0,        32'h0000_1002, 32'h0000_0110, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 1'b0, 32'h0080_0000, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_0080};
        vecs[3]  = '{32'h0,        32'h0000_1001, 32'h0000_0114, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 32'h0000_7F00, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_007F};
        vecs[4]  = '{32'h0,        32'h0000_1003, 32'h0000_0118, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 1'b0, 32'hAB00_0000, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_00AB};
        vecs[5]  = '{32'h0,        32'h0000_1000, 32'h0000_011C, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 32'h1234_56F0, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FFF0};
        vecs[6]  = '{32'h0,        32'h0000_1007, 32'h0000_0120, 1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 32'h0102_0304, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0102_0304};
        vecs[7]  = '{32'h1234_5678, 32'h0000_2003, 32'h0000_0124, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 1'b1, 4'b1000, 32'h7878_7878, 1'b0, 32'h0000_2003};
        vecs[8]  = '{32'h0000_00A5, 32'h0000_2000, 32'h0000_0128, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 1'b1, 4'b0001, 32'hA5A5_A5A5, 1'b0, 32'h0000_2000};
        vecs[9]  = '{32'h0000_005A, 32'h0000_2001, 32'h0000_012C, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0000_2001};
        vecs[10] = '{32'hCAFE_F00D, 32'h0000_2004, 32'h0000_0130, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0000_2004};
        vecs[11] = '{32'h0,        32'h7FFF_FFFF, 32'h0000_0134, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h7FFF_FFFF};
        vecs[12] = '{32'h0,        32'h0000_0055, 32'h0000_0138, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0000_0055};
        vecs[13] = '{32'h0,        32'h0000_1234, 32'h0000_3008, 1'b0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0000_3008};
        vecs[14] = '{32'h0,        32'h0BAD_C0DE, 32'h0000_0140, 1'b0, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0BAD_C0DE};
        vecs[15] = '{32'h0,        32'h0000_1000, 32'h0000_0144, 1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[16] = '{32'hFFFF_FFFF, 32'h0000_2008, 32'h0000_0148, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0000_2008};

        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #4;
        chk("reset Wb_RegWr", {31'd0, Wb_RegWr}, 32'd0);
        chk("reset Wb_busW", Wb_busW, 32'd0);
        chk("reset Wb_Rw", {27'd0, Wb_Rw}, 32'd0);
        chk("reset Wb_instr", Wb_instr, 32'd0);
        chk("reset Wb_pcadd4", Wb_pcadd4, 32'h0000_3000);
        chk("reset dm_req", {31'd0, dm_req}, 32'd0);
        chk("reset bus_err", {31'd0, bus_err}, 32'd0);
        step();

        // Zero-wait ops issued back to back: each completes in its own cycle
        for (int i = 0; i < NV; i++) begin
            Mem_busB = vecs[i].busb; Mem_ALUres = vecs[i].alu; Mem_pcadd4 = vecs[i].pc4;
            Mem_Overflow = vecs[i].ovf; Mem_MemWr = vecs[i].memwr; Mem_MemtoReg = vecs[i].mtr;
            Mem_RegWr = vecs[i].regwr; Mem_lbyte = vecs[i].lbyte; Mem_sbyte = vecs[i].sbyte;
            Mem_Rw = 5'(i + 1); Mem_instr = 32'hA000_0000 + 32'(i);
            dm_rdata = vecs[i].rdata; dm_ack = vecs[i].e_req;
            #4;
            chk($sformatf("v%0d dm_req", i), {31'd0, dm_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d dm_we", i), {31'd0, dm_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d dm_be", i), {28'd0, dm_be}, {28'd0, vecs[i].e_be});
            chk($sformatf("v%0d Mem_stall", i), {31'd0, Mem_stall}, 32'd0);
            if (vecs[i].e_req)
                chk($sformatf("v%0d dm_addr", i), dm_addr, vecs[i].alu & 32'hFFFF_FFFC);
            if (vecs[i].e_we)
                chk($sformatf("v%0d dm_wdata", i), dm_wdata, vecs[i].e_wdata);
            step();
            chk($sformatf("v%0d Wb_RegWr", i), {31'd0, Wb_RegWr}, {31'd0, vecs[i].e_regwr});
            chk($sformatf("v%0d Wb_busW", i), Wb_busW, vecs[i].e_busw);
            chk($sformatf("v%0d Wb_Rw", i), {27'd0, Wb_Rw}, 32'(i + 1));
            chk($sformatf("v%0d Wb_instr", i), Wb_instr, 32'hA000_0000 + 32'(i));
            chk($sformatf("v%0d Wb_pcadd4", i), Wb_pcadd4, vecs[i].pc4);
        end

        // Wait states: lb then lbu issued the cycle after the first completes
        slow_load(2'd1, 32'h0000_2008, 32'hFFFF_FF80);
        slow_load(2'd2, 32'hFFFF_FF80, 32'h0000_0080);

        // Timeout abort, then the pipeline resumes with an ALU op
        run_timeout(5'd10, 1'b0, 32'h1357_2468, 1'b0, 32'd0);
        set_idle();
        Mem_ALUres = 32'h0000_0077; Mem_RegWr = 1'b1; Mem_Rw = 5'd11;
        #4;
        chk("resume dm_req", {31'd0, dm_req}, 32'd0);
        chk("resume stall", {31'd0, Mem_stall}, 32'd0);
        step();
        chk("resume Wb_RegWr", {31'd0, Wb_RegWr}, 32'd1);
        chk("resume Wb_busW", Wb_busW, 32'h0000_0077);

        // Ack in the timeout cycle wins: no bus_err, data written back
        run_timeout(5'd12, 1'b1, 32'h1357_2468, 1'b1, 32'h1357_2468);

        // Reset while BUSY; a late ack afterwards is ignored
        set_load(32'h0000_100C, 2'd0, 5'd13, 32'h5555_AAAA);
        #4;
        chk("rstbusy stall c0", {31'd0, Mem_stall}, 32'd1);
        step();
        #4;
        chk("rstbusy stall c1", {31'd0, Mem_stall}, 32'd1);
        step();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstbusy Wb_pcadd4", Wb_pcadd4, 32'h0000_3000);
        chk("rstbusy Wb_RegWr", {31'd0, Wb_RegWr}, 32'd0);
        chk("rstbusy Wb_busW", Wb_busW, 32'd0);
        chk("rstbusy bus_err", {31'd0, bus_err}, 32'd0);
        chk("rstbusy dm_req", {31'd0, dm_req}, 32'd0);
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        #4;
        chk("late ack stall", {31'd0, Mem_stall}, 32'd0);
        chk("late ack bus_err", {31'd0, bus_err}, 32'd0);
        step();
        chk("late ack Wb_RegWr", {31'd0, Wb_RegWr}, 32'd0);
        dm_ack = 1'b0;

        // Full timeout count again from a clean IDLE
        run_timeout(5'd14, 1'b0, 32'h2468_1357, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
